// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller:
// opcodes, ALU operations, ALU B-input selects and the FSM state set.
package mips_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RWB,
        S_ADDIEX,
        S_ADDIWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_HALT
    } state_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT);
    endfunction

    function automatic logic [2:0] rtype_alu_op(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + ONE;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the 16-bit, 4-register MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back states.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             pc_source,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t     state, next_state;
    logic [2:0] exec_op_q;
    logic       inc;

    // The branch decision is made by the datapath's PC-enable gate, not here.
    logic unused_zero;
    assign unused_zero = zero;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            exec_op_q <= ALU_ADD;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                exec_op_q <= rtype_alu_op(opcode);
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state    = state;
        inc           = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_AND;
        pc_source     = 1'b0;
        halted        = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRANCH;
                alu_op    = ALU_ADD;
                if (is_rtype(opcode))
                    next_state = S_EXEC;
                else if (opcode == OP_ADDI)
                    next_state = S_ADDIEX;
                else if ((opcode == OP_LW) || (opcode == OP_SW))
                    next_state = S_MEMADR;
                else if (opcode == OP_BEQ)
                    next_state = S_BRANCH;
                else if (HALT_ON_ILLEGAL)
                    next_state = S_HALT;
                else begin
                    next_state = S_FETCH;
                    inc        = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = exec_op_q;
                next_state = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                inc        = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                inc        = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                inc        = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    inc        = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                inc           = 1'b1;
                next_state    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase

        // Reset must never let a stray write or memory request escape.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clock (clock),
        .reset (reset),
        .inc   (inc),
        .count (retired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction is expanded from its opcode into the
// expected per-cycle control words, then compared cycle by cycle.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       pc_source;
        logic       halted;
    } ctrl_t;

    typedef struct {
        ctrl_t c;
        bit    need_op;
        bit    rdy;
    } cyc_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic             pw1, pwc1, iord1, mr1, mw1, irw1, m2r1, rw1, rd1, sa1, ps1, h1;
    logic [1:0]       sb1;
    logic [2:0]       ao1;
    logic [CNT_W-1:0] retired1;
    logic             pw2, pwc2, iord2, mr2, mw2, irw2, m2r2, rw2, rd2, sa2, ps2, h2;
    logic [1:0]       sb2;
    logic [2:0]       ao2;
    logic [15:0]      retired2;

    ctrl_t obs1, obs2;
    assign obs1 = {pw1, pwc1, iord1, mr1, mw1, irw1, m2r1, rw1, rd1, sa1, sb1, ao1, ps1, h1};
    assign obs2 = {pw2, pwc2, iord2, mr2, mw2, irw2, m2r2, rw2, rd2, sa2, sb2, ao2, ps2, h2};

    multicycle_control #(.CNT_W(CNT_W), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pw1), .pc_write_cond(pwc1), .iord(iord1), .mem_read(mr1),
        .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_write(rw1),
        .reg_dst(rd1), .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(ao1),
        .pc_source(ps1), .halted(h1), .retired(retired1)
    );

    multicycle_control #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pw2), .pc_write_cond(pwc2), .iord(iord2), .mem_read(mr2),
        .mem_write(mw2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_write(rw2),
        .reg_dst(rd2), .alu_src_a(sa2), .alu_src_b(sb2), .alu_op(ao2),
        .pc_source(ps2), .halted(h2), .retired(retired2)
    );

    always #5 clock = ~clock;

    int               checks = 0;
    int               failures = 0;
    cyc_t             exp_q[$];
    logic [CNT_W-1:0] exp_ret = '0;
    logic [15:0]      exp_ret2 = '0;

    function automatic logic [2:0] ref_alu(input logic [3:0] op);
        case (op)
            4'b0001: return 3'b110;
            4'b0010: return 3'b000;
            4'b0011: return 3'b001;
            4'b0111: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic ctrl_t fetch_word(input bit rdy);
        ctrl_t c = '0;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b010;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        return c;
    endfunction

    task automatic push(input ctrl_t c, input bit need_op, input bit rdy);
        cyc_t e;
        e.c = c;
        e.need_op = need_op;
        e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    // Expand one instruction into its expected cycles; fw/mw are wait cycles.
    task automatic build(input logic [3:0] op, input int fw, input int mw);
        ctrl_t c;
        exp_q.delete();
        for (int i = 0; i <= fw; i++)
            push(fetch_word(i == fw), 1'b0, i == fw);
        c = '0; c.alu_src_b = 2'b11; c.alu_op = 3'b010;
        push(c, 1'b1, 1'($urandom));
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = ref_alu(op);
                push(c, 1'b0, 1'($urandom));
                c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                push(c, 1'b0, 1'($urandom));
            end
            4'b0100: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
                push(c, 1'b0, 1'($urandom));
                c = '0; c.reg_write = 1'b1;
                push(c, 1'b0, 1'($urandom));
            end
            4'b0101, 4'b0110: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
                push(c, 1'b1, 1'($urandom));
                for (int i = 0; i <= mw; i++) begin
                    c = '0; c.iord = 1'b1;
                    if (op == 4'b0101) c.mem_read = 1'b1;
                    else               c.mem_write = 1'b1;
                    push(c, 1'b0, i == mw);
                end
                if (op == 4'b0101) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    push(c, 1'b0, 1'($urandom));
                end
            end
            4'b1000: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b110;
                c.pc_write_cond = 1'b1; c.pc_source = 1'b1;
                push(c, 1'b0, 1'($urandom));
            end
            default: ;
        endcase
    endtask

    // Replay up to ncyc expected cycles (all if ncyc < 0); zmode 2 = random zero.
    task automatic run_q(input logic [3:0] op, input bit use2, input int zmode, input int ncyc);
        ctrl_t got;
        foreach (exp_q[i]) begin
            if (ncyc >= 0 && i >= ncyc) break;
            opcode    = exp_q[i].need_op ? op : 4'($urandom);
            mem_ready = exp_q[i].rdy;
            zero      = (zmode == 2) ? 1'($urandom) : zmode[0];
            #3;
            got = use2 ? obs2 : obs1;
            checks++;
            if (got !== exp_q[i].c) begin
                failures++;
                $display("FAIL ctrl op=%b cycle=%0d got=%b expected=%b", op, i, got, exp_q[i].c);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic check_retired(input string tag);
        checks++;
        if (retired1 !== exp_ret) begin
            failures++;
            $display("FAIL retired %s got=%0d expected=%0d", tag, retired1, exp_ret);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input int zmode);
        build(op, fw, mw);
        run_q(op, 1'b0, zmode, -1);
        if (op <= 4'b1000) exp_ret = exp_ret + 1'b1;
        check_retired("after_instr");
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 4'($urandom);
        #1;
        checks++;
        if ({pw1, pwc1, irw1, rw1, mr1, mw1} !== 6'b0) begin
            failures++;
            $display("FAIL reset_force got=%b expected=000000", {pw1, pwc1, irw1, rw1, mr1, mw1});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        exp_ret = '0;
        exp_ret2 = '0;
        checks++;
        if (retired1 !== '0 || h1 !== 1'b0 || retired2 !== '0) begin
            failures++;
            $display("FAIL reset_state retired=%0d halted=%b retired_nop=%0d expected 0/0/0",
                     retired1, h1, retired2);
        end
    endtask

    task automatic test_reset();
        do_reset();
        mem_ready = 1'b0;
        #3;
        checks++;
        if (obs1 !== fetch_word(1'b0)) begin
            failures++;
            $display("FAIL reset_fetch got=%b expected=%b", obs1, fetch_word(1'b0));
        end
        @(posedge clock); #1;
    endtask

    task automatic test_lw();
        run_instr(4'b0101, 0, 0, 2);
    endtask

    task automatic test_sw_wait();
        run_instr(4'b0110, 0, 3, 2);
    endtask

    task automatic test_beq();
        run_instr(4'b1000, 0, 0, 1);
        run_instr(4'b1000, 0, 0, 0);
    endtask

    task automatic test_slt_addi();
        do_reset();
        run_instr(4'b0111, 0, 0, 2);
        run_instr(4'b0100, 0, 0, 2);
        checks++;
        if (retired1 !== 4'd2) begin
            failures++;
            $display("FAIL slt_addi_retired got=%0d expected=2", retired1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_instr(4'($urandom_range(0, 8)), $urandom_range(0, 2), $urandom_range(0, 3), 2);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 15; n++)
            run_instr(4'b0000, $urandom_range(0, 1), 0, 2);
        checks++;
        if (retired1 !== 4'd15) begin
            failures++;
            $display("FAIL wrap_pre got=%0d expected=15", retired1);
        end
        run_instr(4'b0000, 0, 0, 2);
        checks++;
        if (retired1 !== 4'd0) begin
            failures++;
            $display("FAIL wrap_post got=%0d expected=0", retired1);
        end
    endtask

    task automatic test_reset_mid_memwr();
        run_instr(4'b0000, 0, 0, 2);
        build(4'b0110, 0, 5);
        run_q(4'b0110, 1'b0, 2, 5);
        check_retired("mid_memwr");
        do_reset();
        run_instr(4'b0010, 1, 0, 2);
    endtask

    task automatic test_illegal_halt();
        ctrl_t hw;
        logic [3:0] op;
        hw = '0;
        hw.halted = 1'b1;
        op = 4'($urandom_range(9, 15));
        build(op, 0, 0);
        run_q(op, 1'b0, 2, -1);
        for (int n = 0; n < 10; n++) begin
            opcode = 4'($urandom);
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            #3;
            checks++;
            if (obs1 !== hw) begin
                failures++;
                $display("FAIL halt_hold cycle=%0d got=%b expected=%b", n, obs1, hw);
            end
            check_retired("halt_hold");
            @(posedge clock); #1;
        end
        do_reset();
        run_instr(4'b0011, 0, 0, 2);
    endtask

    task automatic test_illegal_nop();
        do_reset();
        build(4'b1111, 0, 0);
        run_q(4'b1111, 1'b1, 2, -1);
        exp_ret2 = exp_ret2 + 1'b1;
        mem_ready = 1'b0;
        #3;
        checks++;
        if (obs2 !== fetch_word(1'b0) || retired2 !== exp_ret2) begin
            failures++;
            $display("FAIL illegal_nop got=%b retired=%0d expected=%b retired=%0d",
                     obs2, retired2, fetch_word(1'b0), exp_ret2);
        end
        @(posedge clock); #1;
        do_reset();
    endtask

    initial begin
        @(posedge clock); #1;
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_slt_addi();
        test_random();
        test_wrap();
        test_reset_mid_memwr();
        test_illegal_halt();
        test_illegal_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the 16-bit, 4-register MIPS datapath. It replaces the single-cycle combinational main-control decode with a Moore/Mealy FSM. The FSM steps each instruction through fetch, decode, execute, memory and write-back, and waits on a shared instruction/data memory through a ready handshake. It also counts retired instructions and stops on an illegal opcode.

## Interface

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, selects the illegal-opcode response: 1 = enter HALT; 0 = treat the instruction as a NOP and return to FETCH.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  instruction register bits [15:12].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-data select: 1 = memory data register.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  write-register select: 1 = IR[7:6], 0 = IR[9:8].
- alu_src_a  out  1  ALU input A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU input B select: 00 = B, 01 = constant 4, 10 = SignExtend, 11 = SignExtend<<2.
- alu_op  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- halted  out  1  high while in HALT.
- retired  out  CNT_W  count of completed instructions.

## Operation

- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, ADDI 0100, LW 0101, SW 0110, SLT 0111, BEQ 1000. All other opcodes are illegal.
- Outputs default to 0 in every state; each state lists only the outputs it asserts or sets.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=0.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stays in FETCH until mem_ready; then goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=010 (branch target into ALUOut).
  - Next state: R-type → EXEC; ADDI → ADDIEX; LW/SW → MEMADR; BEQ → BRANCH; illegal → HALT (or FETCH if HALT_ON_ILLEGAL=0).
- EXEC: alu_src_a=1, alu_src_b=00, alu_op per opcode (ADD 010, SUB 110, AND 000, OR 001, SLT 111). Next: RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=010. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=010. Next: MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready; then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_source=1. Next: FETCH.
- HALT: halted=1, all enables 0. Only reset leaves HALT.
- retired increments by 1 on the edge that leaves RWB, ADDIWB, MEMWB, BRANCH, or MEMWR with mem_ready=1.
  - With HALT_ON_ILLEGAL=0, it also increments on DECODE → FETCH for an illegal opcode.
  - It wraps modulo 2^CNT_W.

## Timing

- Reset:
  - While reset=1, every write/request output (pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write) is forced to 0 combinationally.
  - On the edge: state=FETCH, retired=0, halted=0.
  - Reset asserted mid-instruction, including mid-MEMWR wait, aborts the instruction with no count.
- Cycles per instruction with mem_ready held at 1: R-type 4, ADDI 4, SW 4, LW 5, BEQ 3, illegal 2 to reach HALT. Each cycle of mem_ready=0 in a wait state adds 1.
- Memory requests stay stable and asserted until mem_ready is sampled high. mem_ready is ignored in all other states.
- opcode is sampled only in DECODE and MEMADR; changes at other times have no effect.

## Structure

- Shared package `mips_pkg` holds:
  - opcode constants;
  - ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - alu_src_b select constants;
  - the state enumeration (4-bit).
- One sub-module, `retire_counter`: CNT_W-bit synchronous counter with clock, reset and inc inputs. The FSM and output decode stay in the top module.

## Test plan

- Reset, then LW (0101) with mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH; reg_write=1 with mem_to_reg=1 only in cycle 5; retired=1.
- SW with mem_ready low for 3 cycles in MEMWR → mem_write=1 and iord=1 held for 4 cycles; retired increments once, on the ready edge.
- BEQ → pc_write_cond=1, pc_source=1, alu_op=110 in cycle 3. Run once with zero=1 and once with zero=0; total 3 cycles; retired=1.
- SLT (0111), then ADDI (0100) → alu_op=111 in EXEC and reg_dst=1 in RWB; then alu_src_b=10 and reg_dst=0 for ADDI; retired=2 after 8 cycles.
- Opcode 1111 with HALT_ON_ILLEGAL=1 → HALT after 2 cycles; halted=1, all enables 0 for 10 cycles, retired unchanged; reset returns state to FETCH and clears retired to 0.
- Preload retired to 2^CNT_W−1 by running instructions (CNT_W=4: 15 ADDs), then one more ADD → retired wraps to 0.
